// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select (branch > jump > stall > +4),
// IF/ID pipeline register with flush/stall, and a saturating redirect counter.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    input  logic             jump_i,
    input  logic [25:0]      jump_index_i,
    input  logic [31:0]      instr_i,
    output logic [31:0]      imem_addr_o,
    output logic [31:0]      pc_plus4_o,
    output logic [31:0]      ifid_instr_o,
    output logic [31:0]      ifid_pc_plus4_o,
    output logic             ifid_valid_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        redirect;

    assign imem_addr_o = pc;
    assign pc_plus4_o  = pc + 32'd4;
    assign redirect    = branch_taken_i | jump_i;

    // Redirects take precedence over stall; the jump region comes from the
    // jump's own PC+4, which is the one sitting in IF/ID.
    always_comb begin
        pc_next = pc_plus4_o;
        if (branch_taken_i)
            pc_next = {branch_target_i[31:2], 2'b00};
        else if (jump_i)
            pc_next = {ifid_pc_plus4_o[31:28], jump_index_i, 2'b00};
        else if (stall_i)
            pc_next = pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= {RESET_PC[31:2], 2'b00};
        else
            pc <= pc_next;
    end

    // Flush keeps ifid_pc_plus4 so a jump following a bubble still sees its region.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_instr_o    <= 32'h0;
            ifid_pc_plus4_o <= 32'h0;
            ifid_valid_o    <= 1'b0;
        end else if (redirect) begin
            ifid_instr_o <= 32'h0;
            ifid_valid_o <= 1'b0;
        end else if (!stall_i) begin
            ifid_instr_o    <= instr_i;
            ifid_pc_plus4_o <= pc_plus4_o;
            ifid_valid_o    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            redirect_cnt_o <= '0;
        else if (redirect && (redirect_cnt_o != {CNT_W{1'b1}}))
            redirect_cnt_o <= redirect_cnt_o + CNT_W'(1);
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed scenarios then random traffic, compared
// cycle by cycle against a spec-level model (two DUTs: CNT_W=16 and CNT_W=2).
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, branch_taken_i, jump_i;
    logic [31:0] branch_target_i;
    logic [25:0] jump_index_i;
    logic [31:0] instr_i, instr2_i;

    logic [31:0] imem_addr_o, pc_plus4_o, ifid_instr_o, ifid_pc_plus4_o;
    logic        ifid_valid_o;
    logic [15:0] redirect_cnt_o;

    logic [31:0] imem_addr2, pc_plus42, ifid_instr2, ifid_pc_plus42;
    logic        ifid_valid2;
    logic [1:0]  redirect_cnt2;

    int tests = 0;
    int fails = 0;

    // model state
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid;
    int          m_cnt, m_cnt2;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0000_1234;
    endfunction

    assign instr_i  = imem(imem_addr_o);
    assign instr2_i = imem(imem_addr2);

    pc_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .jump_i(jump_i), .jump_index_i(jump_index_i), .instr_i(instr_i),
        .imem_addr_o(imem_addr_o), .pc_plus4_o(pc_plus4_o),
        .ifid_instr_o(ifid_instr_o), .ifid_pc_plus4_o(ifid_pc_plus4_o),
        .ifid_valid_o(ifid_valid_o), .redirect_cnt_o(redirect_cnt_o)
    );

    pc_fetch_stage #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .jump_i(jump_i), .jump_index_i(jump_index_i), .instr_i(instr2_i),
        .imem_addr_o(imem_addr2), .pc_plus4_o(pc_plus42),
        .ifid_instr_o(ifid_instr2), .ifid_pc_plus4_o(ifid_pc_plus42),
        .ifid_valid_o(ifid_valid2), .redirect_cnt_o(redirect_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
        m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"},   imem_addr_o,     m_pc);
        chk({tag, ".pp4"},    pc_plus4_o,      m_pc + 32'd4);
        chk({tag, ".instr"},  ifid_instr_o,    m_instr);
        chk({tag, ".ifpp4"},  ifid_pc_plus4_o, m_pp4);
        chk({tag, ".valid"},  {31'b0, ifid_valid_o}, {31'b0, m_valid});
        chk({tag, ".cnt"},    {16'b0, redirect_cnt_o}, 32'(m_cnt));
        chk({tag, ".addr2"},  imem_addr2,      m_pc);
        chk({tag, ".cnt2"},   {30'b0, redirect_cnt2}, 32'(m_cnt2));
    endtask

    // One clock: compute what the spec says happens at this edge, then compare.
    task automatic cycle(input string tag);
        logic [31:0] n_pc, n_instr, n_pp4;
        logic        n_valid;
        logic        redir;
        redir   = branch_taken_i || jump_i;
        n_instr = m_instr; n_pp4 = m_pp4; n_valid = m_valid;
        if (branch_taken_i)  n_pc = branch_target_i & 32'hFFFF_FFFC;
        else if (jump_i)     n_pc = (m_pp4 & 32'hF000_0000) | (32'(jump_index_i) * 4);
        else if (stall_i)    n_pc = m_pc;
        else                 n_pc = m_pc + 32'd4;
        if (redir) begin
            n_instr = 32'h0; n_valid = 1'b0;
        end else if (!stall_i) begin
            n_instr = imem(m_pc); n_pp4 = m_pc + 32'd4; n_valid = 1'b1;
        end
        @(posedge clk); #1;
        m_pc = n_pc; m_instr = n_instr; m_pp4 = n_pp4; m_valid = n_valid;
        if (redir) begin
            m_cnt  = (m_cnt  + 1 > 65535) ? 65535 : m_cnt + 1;
            m_cnt2 = (m_cnt2 + 1 > 3)     ? 3     : m_cnt2 + 1;
        end
        check_all(tag);
    endtask

    task automatic drive(input logic bt, input logic [31:0] tgt, input logic j,
                         input logic [25:0] idx, input logic st);
        branch_taken_i = bt; branch_target_i = tgt;
        jump_i = j; jump_index_i = idx; stall_i = st;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 32'h0, 0, 26'h0, 0);
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("reset_hold");

        // 1: free run
        for (int i = 0; i < 4; i++) cycle("freerun");
        chk("t1.pc10", imem_addr_o, 32'h10);
        chk("t1.valid", {31'b0, ifid_valid_o}, 32'h1);

        // 2: stall at 0x10
        drive(0, 32'h0, 0, 26'h0, 1);
        for (int i = 0; i < 3; i++) cycle("stall");
        chk("t2.frozen", imem_addr_o, 32'h10);
        drive(0, 32'h0, 0, 26'h0, 0);
        cycle("unstall");
        chk("t2.resume", imem_addr_o, 32'h14);

        // 3: branch at 0x20 with misaligned target
        cycle("run"); cycle("run"); cycle("run");
        chk("t3.pc20", imem_addr_o, 32'h20);
        drive(1, 32'h0000_0103, 0, 26'h0, 0);
        cycle("branch");
        chk("t3.target", imem_addr_o, 32'h100);
        chk("t3.bubble", {31'b0, ifid_valid_o}, 32'h0);
        chk("t3.cnt", {16'b0, redirect_cnt_o}, 32'h1);
        drive(0, 32'h0, 0, 26'h0, 0);
        cycle("after_branch");
        chk("t3.first", ifid_instr_o, imem(32'h100));

        // 4: branch + jump + stall together, branch wins
        drive(1, 32'h3000_0004, 0, 26'h0, 0);
        cycle("setup4");
        drive(0, 32'h0, 0, 26'h0, 0);
        cycle("setup4b");
        chk("t4.ifpp4", ifid_pc_plus4_o, 32'h3000_0008);
        drive(1, 32'h40, 1, 26'h0000010, 1);
        cycle("bjs");
        chk("t4.pc", imem_addr_o, 32'h40);
        chk("t4.cnt", {16'b0, redirect_cnt_o}, 32'h3);

        // 5: jump uses region of ifid_pc_plus4
        drive(1, 32'h3000_0004, 0, 26'h0, 0);
        cycle("setup5");
        drive(0, 32'h0, 0, 26'h0, 0);
        cycle("setup5b");
        drive(0, 32'h0, 1, 26'h0000010, 0);
        cycle("jump");
        chk("t5.pc", imem_addr_o, 32'h3000_0040);

        // 6: wrap past 0xFFFF_FFFC, counter saturation on the 2-bit instance
        drive(1, 32'hFFFF_FFFF, 0, 26'h0, 0);
        cycle("to_top");
        chk("t6.top", imem_addr_o, 32'hFFFF_FFFC);
        drive(0, 32'h0, 0, 26'h0, 0);
        cycle("wrap");
        chk("t6.wrap", imem_addr_o, 32'h0);
        chk("t6.sat2", {30'b0, redirect_cnt2}, 32'h3);
        chk("t6.cnt16", {16'b0, redirect_cnt_o}, 32'h6);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(7) == 0), $urandom, ($urandom_range(7) == 0),
                  26'($urandom), ($urandom_range(3) == 0));
            cycle("rand");
        end

        // asynchronous reset mid-cycle
        drive(0, 32'h0, 0, 26'h0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle("post_reset");
        drive(0, 32'h0, 1, 26'h0000ABC, 0);
        cycle("post_jump");
        chk("t6.postjump", imem_addr_o, 32'h0000_2AF0);
        drive(0, 32'h0, 0, 26'h0, 0);
        cycle("post_run");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
